// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and
// the EX-stage handshake levels.
package iter_div_pkg;

    // Divider FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        DIV_FREE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_t;

    // Handshake levels on start_i / ready_o
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/iter_div_div_step.sv
// One radix-2 restoring divide iteration (purely combinational).
// The {rem, quo} word is shifted left by one. The divisor is then subtracted
// from the remainder field. If the difference is non-negative it replaces the
// remainder and a 1 enters the quotient.
module iter_div_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] rq_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [2*WIDTH:0] rq_out
);

    // Trial subtraction carries one guard bit so the borrow is exact
    // even if the top bit of the shifted remainder is set.
    logic [WIDTH+1:0] trial;
    logic             nonneg;

    // Shift, trial-subtract and restore-or-keep selection
    always_comb begin
        trial  = {1'b0, rq_in[2*WIDTH:WIDTH-1]} - {2'b00, divisor};
        nonneg = ~trial[WIDTH+1];
        rq_out = {rq_in[2*WIDTH-1:0], 1'b0};
        if (nonneg) begin
            rq_out[2*WIDTH:WIDTH] = trial[WIDTH:0];
            rq_out[0]             = 1'b1;
        end
    end

endmodule

// File: rtl/iter_div.sv
// Multi-cycle radix-2 restoring divider. This is the responder side of the
// EX-stage divide handshake. It handles signed and unsigned operands and
// returns {remainder, quotient}.
// Optional build macro DIV_EARLY_TERM_EN: when |dividend| < |divisor|, the
// result is returned one cycle after start instead of after the full loop.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [2*WIDTH:0]   rq_reg, rq_next;
    logic [WIDTH-1:0]   dvs_reg, dvs_next;      // divisor magnitude
    logic [WIDTH-1:0]   dvd_reg, dvd_next;      // dividend as presented
    logic               sgn_reg, sgn_next;
    logic               dneg_reg, dneg_next;
    logic               vneg_reg, vneg_next;
    logic [2*WIDTH-1:0] result_reg, result_next;
    logic               ready_reg, ready_next;

    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [2*WIDTH:0]   step_out;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    iter_div_div_step #(.WIDTH(WIDTH)) u_step (
        .rq_in   (rq_reg),
        .divisor (dvs_reg),
        .rq_out  (step_out)
    );

    // Operand magnitudes, plus sign fixup applied to the final iteration's output
    always_comb begin
        op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        quo_fix = step_out[WIDTH-1:0];
        rem_fix = step_out[2*WIDTH-1:WIDTH];
        if (sgn_reg && (dneg_reg ^ vneg_reg)) begin
            quo_fix = -step_out[WIDTH-1:0];
        end
        if (sgn_reg && dneg_reg) begin
            rem_fix = -step_out[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state and datapath update for the divide FSM
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rq_next     = rq_reg;
        dvs_next    = dvs_reg;
        dvd_next    = dvd_reg;
        sgn_next    = sgn_reg;
        dneg_next   = dneg_reg;
        vneg_next   = vneg_reg;
        result_next = result_reg;
        ready_next  = ready_reg;
        case (state_reg)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    sgn_next  = signed_div_i;
                    dneg_next = signed_div_i & opdata1_i[WIDTH-1];
                    vneg_next = signed_div_i & opdata2_i[WIDTH-1];
                    dvd_next  = opdata1_i;
                    if (opdata2_i == '0) begin
                        state_next = DIV_ZERO;
                    end
`ifdef DIV_EARLY_TERM_EN
                    else if (op1_mag < op2_mag) begin
                        // Quotient is zero and the remainder is the dividend itself
                        state_next  = DIV_END;
                        result_next = {opdata1_i, {WIDTH{1'b0}}};
                        ready_next  = DIV_RESULT_READY;
                    end
`endif
                    else begin
                        dvs_next   = op2_mag;
                        rq_next    = {{(WIDTH+1){1'b0}}, op1_mag};
                        cnt_next   = '0;
                        state_next = DIV_ON;
                    end
                end
            end
            DIV_ZERO: begin
                if (annul_i) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else begin
                    state_next  = DIV_END;
                    result_next = {dvd_reg, {WIDTH{1'b1}}};
                    ready_next  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else begin
                    rq_next  = step_out;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        state_next  = DIV_END;
                        result_next = {rem_fix, quo_fix};
                        ready_next  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end
            end
            default: begin
                state_next = DIV_FREE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= DIV_FREE;
            cnt_reg    <= '0;
            rq_reg     <= '0;
            dvs_reg    <= '0;
            dvd_reg    <= '0;
            sgn_reg    <= 1'b0;
            dneg_reg   <= 1'b0;
            vneg_reg   <= 1'b0;
            result_reg <= '0;
            ready_reg  <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rq_reg     <= rq_next;
            dvs_reg    <= dvs_next;
            dvd_reg    <= dvd_next;
            sgn_reg    <= sgn_next;
            dneg_reg   <= dneg_next;
            vneg_reg   <= vneg_next;
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_iter_div.sv
// Directed testbench for iter_div: table-driven divides plus handshake,
// annul and reset sequences.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks   = 0;
    int failures = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 33;
`endif
    localparam int FULL_LAT = 33;
    localparam int ZERO_LAT = 2;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    iter_div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic add_vec(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] e, input int l, input string n);
        vec_t v;
        v.sgn = s; v.a = a; v.b = b; v.exp = e; v.lat = l; v.name = n;
        vecs.push_back(v);
    endtask

    // Count edges from the start-accepting edge until ready_o is seen (bounded)
    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
        end
    endtask

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input int l, input string n);
        int lat;
        @(negedge clk);
        signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1;
        wait_ready(lat);
        chk({n, " latency"}, 64'(lat), 64'(l));
        chk({n, " result"}, result, e);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk({n, " ready_drop"}, 64'(ready), 64'd0);
        chk({n, " result_clear"}, result, 64'd0);
    endtask

    // Holds idle inputs for n cycles and reports how often ready_o was seen high
    task automatic idle_count(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready) highs++;
        end
    endtask

    initial begin
        int lat;
        int highs;
        rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
        start = 1'b0; annul = 1'b0;

        add_vec(1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        FULL_LAT,  "u100/7");
        add_vec(1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, FULL_LAT,  "s-7/2");
        add_vec(1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, FULL_LAT,  "s7/-2");
        add_vec(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0,         32'h8000_0000}, FULL_LAT,  "smin/-1");
        add_vec(1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0,         32'hFFFF_FFFF}, FULL_LAT,  "umax/1");
        add_vec(1'b0, 32'h0000_1234, 32'd0,         {32'h0000_1234, 32'hFFFF_FFFF}, ZERO_LAT,  "u1234/0");
        add_vec(1'b1, 32'hFFFF_FFF0, 32'd0,         {32'hFFFF_FFF0, 32'hFFFF_FFFF}, ZERO_LAT,  "s-16/0");
        add_vec(1'b0, 32'd3,         32'd10,        {32'd3,         32'd0},         SMALL_LAT, "u3/10");
        add_vec(1'b1, 32'hFFFF_FFFD, 32'd10,        {32'hFFFF_FFFD, 32'd0},         SMALL_LAT, "s-3/10");
        add_vec(1'b1, 32'd0,         32'd5,         {32'd0,         32'd0},         SMALL_LAT, "s0/5");
        add_vec(1'b0, 32'h8000_0000, 32'd3,         {32'd2,         32'h2AAA_AAAA}, FULL_LAT,  "u2^31/3");
        add_vec(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        FULL_LAT,  "s-100/-7");
        add_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0,         32'd1},         FULL_LAT,  "umax/umax");

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);
        end

        // Annul in the 10th cycle of ON, then a clean 9/3
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("annul_on ready", 64'(ready), 64'd0);
        chk("annul_on result", result, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        idle_count(40, highs);
        chk("annul_on ready_high_count", 64'(highs), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, FULL_LAT, "after_annul 9/3");

        // Annul while in ZERO
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        idle_count(5, highs);
        chk("annul_zero ready_high_count", 64'(highs), 64'd0);

        // Operands change while ON: latched values must be used
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        @(negedge clk);
        signed_div = 1'b1; opdata1 = 32'd5; opdata2 = 32'd0;
        wait_ready(lat);
        chk("latched latency", 64'(lat), 64'(FULL_LAT - 1));
        chk("latched result", result, {32'd2, 32'd14});

        // annul ignored in END: result held while start stays high
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_end ready", 64'(ready), 64'd1);
        chk("annul_end result", result, {32'd2, 32'd14});
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("end_release ready", 64'(ready), 64'd0);

        // Reset during the 5th cycle of ON
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midrst ready", 64'(ready), 64'd0);
        chk("midrst result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_count(40, highs);
        chk("midrst ready_high_count", 64'(highs), 64'd0);
        do_div(1'b1, 32'hFFFF_FFF7, 32'd3, {32'd0, 32'hFFFF_FFFD}, FULL_LAT, "after_rst s-9/3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
